// File: rtl/aer_event_fifo.sv
// aer_event_fifo
//   Captures each pixel address granted by the hierarchical arbiter and stamps
//   it with a free-running timestamp. The stamped events go into a synchronous
//   FIFO and leave through a valid/ready interface as address-event words.
//   A marker word is inserted whenever the timestamp is about to wrap. The
//   arbiter is told to hold its grant through stall_o.
//
// Ports
//   clk_i        : clock, everything on the rising edge
//   reset_i      : synchronous reset, active low
//   active_i     : arbiter has a grant this cycle
//   x_add_i      : column address of the granted pixel
//   y_add_i      : row address of the granted pixel
//   stall_o      : event not accepted this cycle; upstream holds the grant
//   evt_valid_o  : FIFO head is valid
//   evt_data_o   : {marker, ts, y, x} of the FIFO head (zero when empty)
//   evt_ready_i  : consumer takes the head when evt_valid_o is also high
//   level_o      : FIFO occupancy
//   overflow_o   : sticky, a wrap marker was lost
module aer_event_fifo #(
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       active_i,
    input  logic [ADDR_W-1:0]          x_add_i,
    input  logic [ADDR_W-1:0]          y_add_i,
    output logic                       stall_o,
    output logic                       evt_valid_o,
    output logic [TS_W+2*ADDR_W:0]     evt_data_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 1 + TS_W + 2 * ADDR_W;

    localparam logic [EW-1:0] MARKER_WORD = {1'b1, {TS_W{1'b1}}, {(2*ADDR_W){1'b0}}};

    logic [TS_W-1:0] ts_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            marker_pend;
    logic            overflow_q;
    logic [EW-1:0]   mem [DEPTH];

    logic            wrap_now;
    logic            full;
    logic            empty;
    logic            marker_req;
    logic            wr_en;
    logic            rd_en;
    logic [EW-1:0]   wr_word;

    // full/empty depend only on the pointer flops, so stall_o never sees a
    // same-cycle pop and a full FIFO always refuses the write in that cycle.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign wrap_now   = (ts_q == {TS_W{1'b1}});
    // A fresh wrap request merges with one that is already pending.
    assign marker_req = marker_pend | wrap_now;

    assign stall_o = full | marker_pend | wrap_now;

    // Markers own the write port whenever one is requested; stall_o is then
    // high, so a pixel can never compete with a marker for the same slot.
    assign wr_en   = marker_req ? ~full : (active_i & ~stall_o);
    assign wr_word = marker_req ? MARKER_WORD : {1'b0, ts_q, y_add_i, x_add_i};
    assign rd_en   = ~empty & evt_ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ts_q        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            marker_pend <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_q + 1'b1;
            marker_pend <= marker_req & full;
            if (wrap_now && marker_pend) begin
                overflow_q <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    assign evt_valid_o = ~empty;
    assign evt_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign level_o     = wr_ptr - rd_ptr;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_aer_event_fifo.sv
module tb_aer_event_fifo;

    localparam int ADDR_W = 4;
    localparam int TS_W   = 4;
    localparam int DEPTH  = 8;
    localparam int EW     = 1 + TS_W + 2 * ADDR_W;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam logic [EW-1:0] MARK = 13'h1F00;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_in;
    logic              rdy_in;
    logic [ADDR_W-1:0] x_in;
    logic [ADDR_W-1:0] y_in;
    logic              stall;
    logic              vld;
    logic [EW-1:0]     data;
    logic [LW-1:0]     lvl;
    logic              ovf;

    always #5 clk = ~clk;

    aer_event_fifo #(.ADDR_W(ADDR_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .active_i    (a_in),
        .x_add_i     (x_in),
        .y_add_i     (y_in),
        .stall_o     (stall),
        .evt_valid_o (vld),
        .evt_data_o  (data),
        .evt_ready_i (rdy_in),
        .level_o     (lvl),
        .overflow_o  (ovf)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural reference: a queue of stored words plus timestamp/marker flags.
    logic [EW-1:0]   q[$];
    logic [TS_W-1:0] ts_m = '0;
    bit              pend_m = 0;
    bit              ovf_m = 0;

    typedef struct {
        logic              a;
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] y;
        logic              r;
        logic              st;
        logic              v;
        logic [EW-1:0]     d;
        logic [LW-1:0]     lv;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic a, input logic [ADDR_W-1:0] x,
                         input logic [ADDR_W-1:0] y, input logic r);
        rst_n  = rs;
        a_in   = a;
        x_in   = x;
        y_in   = y;
        rdy_in = r;
    endtask

    task automatic check_model();
        bit m_full;
        m_full = (q.size() == DEPTH);
        chk("stall", {31'b0, stall}, {31'b0, (m_full || pend_m || ts_m == '1)});
        chk("valid", {31'b0, vld}, {31'b0, (q.size() > 0)});
        chk("data", {19'b0, data}, {19'b0, (q.size() > 0) ? q[0] : '0});
        chk("level", {28'b0, lvl}, q.size());
        chk("overflow", {31'b0, ovf}, {31'b0, ovf_m});
    endtask

    // Apply the model's rules for the edge about to happen, then take the edge.
    task automatic advance();
        bit            m_full;
        bit            m_stall;
        bit            m_pop;
        bit            do_w;
        logic [EW-1:0] w;
        m_full  = (q.size() == DEPTH);
        m_stall = m_full || pend_m || (ts_m == '1);
        m_pop   = (q.size() > 0) && rdy_in;
        do_w    = 0;
        w       = '0;
        if (!rst_n) begin
            q.delete();
            ts_m   = '0;
            pend_m = 0;
            ovf_m  = 0;
        end else begin
            if (ts_m == '1 && pend_m) ovf_m = 1;
            if (ts_m == '1 || pend_m) begin
                if (!m_full) begin
                    w = MARK;
                    do_w = 1;
                    pend_m = 0;
                end else begin
                    pend_m = 1;
                end
            end else if (a_in && !m_stall) begin
                w = {1'b0, ts_m, y_in, x_in};
                do_w = 1;
            end
            if (m_pop) void'(q.pop_front());
            if (do_w) q.push_back(w);
            ts_m = ts_m + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rs, input logic a, input logic [ADDR_W-1:0] x,
                        input logic [ADDR_W-1:0] y, input logic r);
        drive(rs, a, x, y, r);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        advance();
        advance();
    endtask

    initial begin
        // Idle rows by default, then the single-event and wrap-collision rows.
        for (int i = 0; i < 20; i++) tbl[i] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 13'h0, 4'd0};
        tbl[10] = '{1'b1, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0, 13'h0,    4'd0};
        tbl[11] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 13'h0A53, 4'd1};
        tbl[15] = '{1'b1, 4'd7, 4'd2, 1'b1, 1'b1, 1'b0, 13'h0,    4'd0};
        tbl[16] = '{1'b1, 4'd7, 4'd2, 1'b0, 1'b0, 1'b1, 13'h1F00, 4'd1};
        tbl[17] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 13'h1F00, 4'd2};
        tbl[18] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 13'h0027, 4'd1};

        do_reset();
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_valid", {31'b0, vld}, 0);
        chk("rst_data", {19'b0, data}, 0);
        chk("rst_level", {28'b0, lvl}, 0);
        chk("rst_ovf", {31'b0, ovf}, 0);

        // Table: rows start at ts=0 right after reset.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].x, tbl[i].y, tbl[i].r);
            chk($sformatf("tbl%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].st});
            chk($sformatf("tbl%0d_valid", i), {31'b0, vld}, {31'b0, tbl[i].v});
            chk($sformatf("tbl%0d_data", i), {19'b0, data}, {19'b0, tbl[i].d});
            chk($sformatf("tbl%0d_level", i), {28'b0, lvl}, {28'b0, tbl[i].lv});
            advance();
        end

        // Backpressure: 10 offered events, 8 stored, then one pop frees a slot.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'(i), 4'(i + 1), 1'b0);
        chk("bp_level", {28'b0, lvl}, 8);
        chk("bp_stall", {31'b0, stall}, 1);
        step(1'b1, 1'b1, 4'd9, 4'd10, 1'b1);
        chk("bp_unstall", {31'b0, stall}, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd9, 4'd10, 1'b0);

        // Simultaneous push/pop at level 3, and pop while full.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'(i), 4'd1, 1'b0);
        step(1'b1, 1'b1, 4'd3, 4'd1, 1'b1);
        chk("pp_level3", {28'b0, lvl}, 3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i + 4), 4'd2, 1'b0);
        chk("pp_full", {28'b0, lvl}, 8);
        step(1'b1, 1'b1, 4'd12, 4'd2, 1'b1);
        chk("pp_full_pop", {28'b0, lvl}, 7);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);

        // Pending marker and overflow: full across two wraps.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 4'(i), 4'(~i), 1'b0);
        chk("pm_overflow", {31'b0, ovf}, 1);
        step(1'b1, 1'b1, 4'd1, 4'd1, 1'b1);
        step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0);
        chk("pm_marker_level", {28'b0, lvl}, 8);
        chk("pm_marker_stall", {31'b0, stall}, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
        chk("pm_marker_head", {19'b0, data}, {19'b0, MARK});
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);

        // Reset in the middle of operation with stored events and overflow set.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i), 4'd3, 1'b0);
        step(1'b0, 1'b1, 4'd2, 4'd2, 1'b1);
        chk("mr_valid", {31'b0, vld}, 0);
        chk("mr_data", {19'b0, data}, 0);
        chk("mr_level", {28'b0, lvl}, 0);
        chk("mr_stall", {31'b0, stall}, 0);
        chk("mr_ovf", {31'b0, ovf}, 0);
        step(1'b1, 1'b1, 4'd9, 4'd4, 1'b0);
        chk("mr_first_ts0", {19'b0, data}, 32'h0049);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 300) % 2) ? 3 : 8;
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
                 4'($urandom), 4'($urandom), ($urandom_range(0, 9) < bias));
        end
        check_model();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
